// File: rtl/mask_rng_multi.sv
// Multi-lane xorshift32 mask generator: two-beat seed load, programmable warm-up,
// then CHANNELS mask words per valid/ready beat in truncate or rejection-below-Q mode.
module mask_rng_multi #(
    parameter int          COEFF_SZ  = 16,
    parameter int          CHANNELS  = 4,
    parameter int          MASK_BITS = 11,
    parameter int          QBITS     = 12,
    parameter int          KYBER_Q   = 3329,
    parameter int          MODE      = 0,
    parameter int          WARMUP    = 4,
    parameter logic [31:0] S1        = 32'h40bfe3a7
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         seed_valid,
    input  logic [COEFF_SZ-1:0]          seed_data,
    output logic                         seed_ready,
    output logic                         rand_valid,
    input  logic                         rand_ready,
    output logic [CHANNELS*COEFF_SZ-1:0] rand_data,
    output logic                         busy
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WARMUP, ST_RUN} state_t;

    localparam logic [31:0]         GOLDEN    = 32'h9E3779B9;
    localparam logic [COEFF_SZ-1:0] Q_BOUND   = COEFF_SZ'(KYBER_Q);
    localparam logic [7:0]          WARM_LAST = 8'(WARMUP - 1);
    localparam int                  KEEP_BITS = (MODE == 0) ? MASK_BITS : QBITS;

    function automatic logic [31:0] xs32(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x << 13);
        y = y ^ (y >> 17);
        y = y ^ (y << 5);
        return y;
    endfunction

    function automatic logic [31:0] seed_lane(input int idx, input logic [31:0] seed32);
        logic [31:0] s;
        s = S1 ^ seed32 ^ (32'(idx) * GOLDEN);
        return (s == '0) ? S1 : s;  // xorshift never leaves the all-zero state
    endfunction

    function automatic logic [COEFF_SZ-1:0] lane_word(input logic [31:0] s);
        logic [COEFF_SZ-1:0] w;
        w = '0;
        for (int b = 0; b < COEFF_SZ; b++)
            if (b < KEEP_BITS) w[b] = s[b];
        return w;
    endfunction

    state_t                       state, state_nxt;
    logic [31:0]                  lane     [CHANNELS];
    logic [31:0]                  lane_nxt [CHANNELS];
    logic [15:0]                  beat0, beat0_nxt;
    logic [7:0]                   warm_cnt, warm_nxt;
    logic                         valid_nxt, step, seed_acc;
    logic [CHANNELS*COEFF_SZ-1:0] rand_nxt;

    assign seed_ready = (state != ST_WARMUP);
    assign busy       = (state == ST_LOAD) || (state == ST_WARMUP);
    assign seed_acc   = seed_valid & seed_ready;

    // NOTE: every variable gets a default first so no path through the case can infer a latch.
    always_comb begin
        state_nxt = state;
        beat0_nxt = beat0;
        warm_nxt  = warm_cnt;
        step      = 1'b0;
        for (int i = 0; i < CHANNELS; i++) lane_nxt[i] = lane[i];

        case (state)
            ST_IDLE: begin
                if (seed_acc) begin
                    beat0_nxt = seed_data[15:0];
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (seed_acc) begin
                    for (int i = 0; i < CHANNELS; i++)
                        lane_nxt[i] = seed_lane(i, {beat0, seed_data[15:0]});
                    warm_nxt  = '0;
                    state_nxt = (WARMUP == 0) ? ST_RUN : ST_WARMUP;
                end
            end
            ST_WARMUP: begin
                step     = 1'b1;
                warm_nxt = warm_cnt + 8'd1;
                if (warm_cnt == WARM_LAST) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                // A rejected set is discarded without waiting for the consumer.
                step = !rand_valid || rand_ready;
                if (seed_acc) begin
                    beat0_nxt = seed_data[15:0];
                    state_nxt = ST_LOAD;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        if (step)
            for (int i = 0; i < CHANNELS; i++) lane_nxt[i] = xs32(lane[i]);

        // Outputs are registered images of the lane states they describe.
        valid_nxt = 1'b0;
        rand_nxt  = '0;
        if (state_nxt == ST_RUN) begin
            valid_nxt = 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                rand_nxt[i*COEFF_SZ +: COEFF_SZ] = lane_word(lane_nxt[i]);
                if (MODE != 0 && lane_word(lane_nxt[i]) >= Q_BOUND) valid_nxt = 1'b0;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only; the lane array is reset like any flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            beat0      <= '0;
            warm_cnt   <= '0;
            rand_valid <= 1'b0;
            rand_data  <= '0;
            for (int i = 0; i < CHANNELS; i++) lane[i] <= S1;
        end else begin
            state      <= state_nxt;
            beat0      <= beat0_nxt;
            warm_cnt   <= warm_nxt;
            rand_valid <= valid_nxt;
            rand_data  <= rand_nxt;
            for (int i = 0; i < CHANNELS; i++) lane[i] <= lane_nxt[i];
        end
    end

endmodule

// File: tb/tb_mask_rng_multi.sv
// Bench for mask_rng_multi: three configurations driven in lock-step, checked each cycle
// against a spec-level model, plus hand-computed literal expectations.
module tb_mask_rng_multi;

    localparam logic [31:0] S1 = 32'h40bfe3a7;
    localparam int CH [3] = '{1, 4, 4};
    localparam int WU [3] = '{0, 4, 0};
    localparam int MD [3] = '{0, 0, 1};
    localparam int P_IDLE = 0, P_LOAD = 1, P_WARM = 2, P_RUN = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_valid = 1'b0;
    logic [15:0] seed_data = '0;
    logic        rand_ready = 1'b0;

    logic        dv [3];
    logic        dsr [3];
    logic        dbusy [3];
    logic [15:0] rand_a;
    logic [63:0] rand_b, rand_c;
    logic [63:0] drand [3];

    assign drand[0] = {48'b0, rand_a};
    assign drand[1] = rand_b;
    assign drand[2] = rand_c;

    always #5 clk = ~clk;

    mask_rng_multi #(.CHANNELS(1), .WARMUP(0), .MODE(0)) dut_a (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(dsr[0]), .rand_valid(dv[0]), .rand_ready(rand_ready),
        .rand_data(rand_a), .busy(dbusy[0]));
    mask_rng_multi #(.CHANNELS(4), .WARMUP(4), .MODE(0)) dut_b (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(dsr[1]), .rand_valid(dv[1]), .rand_ready(rand_ready),
        .rand_data(rand_b), .busy(dbusy[1]));
    mask_rng_multi #(.CHANNELS(4), .WARMUP(0), .MODE(1)) dut_c (
        .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed_data(seed_data),
        .seed_ready(dsr[2]), .rand_valid(dv[2]), .rand_ready(rand_ready),
        .rand_data(rand_c), .busy(dbusy[2]));

    int n_pass = 0;
    int n_total = 0;
    bit cmp_en = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // ---------------- spec-level model ----------------
    int          m_phase [3];
    int          m_warm  [3];
    logic [15:0] m_beat0 [3];
    logic [31:0] m_lane  [3][4];

    function automatic logic [31:0] m_xs(input logic [31:0] x);
        logic [31:0] y;
        y = x ^ (x * 32'd8192);
        y = y ^ (y / 32'd131072);
        y = y ^ (y * 32'd32);
        return y;
    endfunction

    function automatic logic [15:0] m_word(input int k, input logic [31:0] s);
        return 16'(s % ((MD[k] != 0) ? 32'd4096 : 32'd2048));
    endfunction

    function automatic logic m_valid(input int k);
        logic ok;
        ok = (m_phase[k] == P_RUN);
        if (MD[k] != 0)
            for (int i = 0; i < CH[k]; i++)
                if (m_word(k, m_lane[k][i]) >= 16'd3329) ok = 1'b0;
        return ok;
    endfunction

    function automatic logic [63:0] m_rand(input int k);
        logic [63:0] r;
        r = '0;
        if (m_phase[k] == P_RUN)
            for (int i = 0; i < CH[k]; i++) r[i*16 +: 16] = m_word(k, m_lane[k][i]);
        return r;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            logic v, go;
            logic [31:0] s;
            v = m_valid(k);
            if (rst) begin
                m_phase[k] = P_IDLE;
                m_warm[k]  = 0;
                m_beat0[k] = '0;
                for (int i = 0; i < 4; i++) m_lane[k][i] = S1;
            end else if (m_phase[k] == P_IDLE) begin
                if (seed_valid) begin m_beat0[k] = seed_data; m_phase[k] = P_LOAD; end
            end else if (m_phase[k] == P_LOAD) begin
                if (seed_valid) begin
                    for (int i = 0; i < CH[k]; i++) begin
                        s = S1 ^ {m_beat0[k], seed_data} ^ (32'(i) * 32'h9E3779B9);
                        m_lane[k][i] = (s == 0) ? S1 : s;
                    end
                    m_warm[k]  = WU[k];
                    m_phase[k] = (WU[k] == 0) ? P_RUN : P_WARM;
                end
            end else begin
                go = (m_phase[k] == P_WARM) || !v || rand_ready;
                if (go) for (int i = 0; i < CH[k]; i++) m_lane[k][i] = m_xs(m_lane[k][i]);
                if (m_phase[k] == P_WARM) begin
                    m_warm[k]--;
                    if (m_warm[k] == 0) m_phase[k] = P_RUN;
                end else if (seed_valid) begin
                    m_beat0[k] = seed_data;
                    m_phase[k] = P_LOAD;
                end
            end
        end
    end

    // ---------------- per-cycle comparison ----------------
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int k = 0; k < 3; k++) begin
                check($sformatf("dut%0d_valid", k), 64'(dv[k]), 64'(m_valid(k)));
                check($sformatf("dut%0d_rand", k), drand[k], m_rand(k));
                check($sformatf("dut%0d_seed_ready", k), 64'(dsr[k]), 64'(m_phase[k] != P_WARM));
                check($sformatf("dut%0d_busy", k), 64'(dbusy[k]),
                      64'(m_phase[k] == P_LOAD || m_phase[k] == P_WARM));
            end
        end
    end

    // ---------------- directed stimulus ----------------
    int busy_cnt [3];

    task automatic tally_busy();
        for (int k = 0; k < 3; k++) if (dbusy[k]) busy_cnt[k]++;
    endtask

    task automatic send_seed(input logic [15:0] hi, input logic [15:0] lo);
        seed_valid = 1'b1;
        seed_data  = hi;
        @(negedge clk); tally_busy();
        seed_data  = lo;
        @(negedge clk); tally_busy();
        seed_valid = 1'b0;
        seed_data  = '0;
    endtask

    function automatic int dup_pairs(input logic [63:0] r);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++)
            for (int j = i + 1; j < 4; j++)
                if (r[i*16 +: 16] == r[j*16 +: 16]) n++;
        return n;
    endfunction

    initial begin
        int hs;
        int bad;

        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst%0d_valid", k), 64'(dv[k]), 64'd0);
            check($sformatf("rst%0d_rand", k), drand[k], 64'd0);
            check($sformatf("rst%0d_seed_ready", k), 64'(dsr[k]), 64'd1);
            check($sformatf("rst%0d_busy", k), 64'(dbusy[k]), 64'd0);
        end
        rst    = 1'b0;
        cmp_en = 1'b1;
        @(negedge clk);

        // Seed giving lane0 = 1 on the single-lane instance, then hold with rand_ready low.
        send_seed(16'h40bf, 16'he3a6);
        check("a_first_rand", 64'(rand_a), 64'h0001);
        check("a_first_valid", 64'(dv[0]), 64'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("a_hold_rand", 64'(rand_a), 64'h0001);
            check("a_hold_valid", 64'(dv[0]), 64'd1);
        end
        rand_ready = 1'b1;
        @(negedge clk);
        rand_ready = 1'b0;
        check("a_after_hs_rand", 64'(rand_a), 64'h0021);
        repeat (3) @(negedge clk);
        check("a_no_step_rand", 64'(rand_a), 64'h0021);

        // Zero seed: busy spans LOAD plus the warm-up on the four-lane instance.
        for (int k = 0; k < 3; k++) busy_cnt[k] = 0;
        send_seed(16'h0000, 16'h0000);
        repeat (8) begin @(negedge clk); tally_busy(); end
        check("b_busy_cycles", 64'(busy_cnt[1]), 64'd5);
        check("a_busy_cycles", 64'(busy_cnt[0]), 64'd1);
        check("c_busy_cycles", 64'(busy_cnt[2]), 64'd1);
        check("b_lane_dup_pairs", 64'(dup_pairs(rand_b)), 64'(dup_pairs(m_rand(1))));

        // Rejection mode: lane0 = 0xFFF, whose successor 0x3E020F00 is also rejected.
        send_seed(16'h40bf, 16'hec58);
        check("c_reject_valid", 64'(dv[2]), 64'd0);
        check("c_reject_lane0", 64'(rand_c[11:0]), 64'hfff);
        @(negedge clk);
        check("c_reject2_valid", 64'(dv[2]), 64'd0);
        check("c_reject2_lane0", 64'(rand_c[11:0]), 64'hf00);

        rand_ready = 1'b1;
        hs = 0;
        for (int cyc = 0; cyc < 20000 && hs < 1000; cyc++) begin
            @(negedge clk);
            if (dv[2]) begin
                hs++;
                bad = 0;
                for (int i = 0; i < 4; i++) if (rand_c[i*16 +: 16] >= 16'd3329) bad++;
                check("c_accepted_below_q", 64'(bad), 64'd0);
            end
        end
        check("c_handshake_count", 64'(hs), 64'd1000);

        // Reseed mid-stream, then reset during LOAD.
        seed_valid = 1'b1;
        seed_data  = 16'h1234;
        @(negedge clk);
        seed_valid = 1'b0;
        seed_data  = '0;
        rand_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("reseed%0d_valid", k), 64'(dv[k]), 64'd0);
            check($sformatf("reseed%0d_busy", k), 64'(dbusy[k]), 64'd1);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("midrst%0d_busy", k), 64'(dbusy[k]), 64'd0);
            check($sformatf("midrst%0d_seed_ready", k), 64'(dsr[k]), 64'd1);
            check($sformatf("midrst%0d_valid", k), 64'(dv[k]), 64'd0);
        end
        send_seed(16'h40bf, 16'he3a6);
        check("a_fresh_seed_rand", 64'(rand_a), 64'h0001);
        check("a_fresh_seed_valid", 64'(dv[0]), 64'd1);

        repeat (10) @(negedge clk);
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation did not complete");
    end

endmodule

// File: doc/mask_rng_multi.md
Name: mask_rng_multi

Overview:
- Parametrised successor to the single-lane unpack mask generator.
- Produces CHANNELS independent COEFF_SZ-bit mask words per beat from per-lane xorshift32 generators.
- Seeded over a multi-beat seed port, then runs a programmable warm-up.
- Delivers masks over a valid/ready handshake, with either bit-truncation or rejection-below-Q output mode.
- Feeds the masked unpack/decode stages that consume one mask per coefficient lane.

Parameters:
- COEFF_SZ, 16, width of each output mask word and of each seed beat.
- CHANNELS, 4, number of parallel mask lanes (1..8).
- MASK_BITS, 11, mode 0: number of LSBs kept per lane (1..COEFF_SZ).
- QBITS, 12, mode 1: number of LSBs compared against KYBER_Q.
- KYBER_Q, 3329, rejection bound for mode 1.
- MODE, 0, 0 = truncate, 1 = rejection sampling (all lanes < KYBER_Q).
- WARMUP, 4, generator advances after seed load before first valid (0..255).
- S1, 32'h40bfe3a7, base seed constant.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous reset, active-high
- seed_valid  in  1  seed beat present
- seed_data  in  COEFF_SZ  seed beat
- seed_ready  out  1  block accepts seed beats
- rand_valid  out  1  rand bus holds a fresh mask set
- rand_ready  in  1  consumer takes mask set
- rand  out  CHANNELS*COEFF_SZ  lane i at bits [i*COEFF_SZ +: COEFF_SZ]
- busy  out  1  high in LOAD or WARMUP

Behaviour:
- Reset, synchronous with rst=1 on a clk edge:
  - FSM to IDLE; all lane states = S1.
  - rand_valid=0, rand=0, busy=0, seed_ready=1, beat counter=0, warm counter=0.
- FSM states: IDLE, LOAD, WARMUP, RUN.
- IDLE:
  - seed_ready=1; rand_valid=0.
  - A seed beat (seed_valid & seed_ready) is captured as beat 0 and the FSM moves to LOAD.
- LOAD:
  - seed_ready=1; the next accepted beat is beat 1.
  - seed32 = {beat0, beat1}; the upper half arrives first.
  - Seed beats are COEFF_SZ wide; seed32 is formed from the low 16 bits of each beat.
  - On the cycle after beat 1: lane i state = (S1 ^ seed32) ^ (i * 32'h9E3779B9), mod 2^32.
  - A lane state that evaluates to 0 is replaced by S1.
  - Then go to WARMUP, or directly to RUN if WARMUP=0.
- Xorshift32 step, per lane:
  - x ^= x<<13; x ^= x>>17; x ^= x<<5; all 32-bit, shifts zero-fill.
- WARMUP:
  - All lanes step every cycle for exactly WARMUP cycles.
  - seed_ready=0; rand_valid=0. Then go to RUN.
- RUN:
  - Mode 0: lane word = state[COEFF_SZ-1:0] & ((1<<MASK_BITS)-1); rand_valid=1 continuously.
  - Mode 1: lane word = zero-extended state[QBITS-1:0]. rand_valid=1 only when every lane word < KYBER_Q. On any rejection, rand_valid=0 and all lanes step that cycle without a handshake.
  - On rand_valid & rand_ready, all lanes step. The next mask set appears on the following cycle (zero bubble in mode 0).
  - When rand_valid=1 and rand_ready=0: rand holds stable and lanes do not step.
  - rand is registered from the lane states, so the word presented equals the current state before stepping.
  - seed_ready=1 in RUN. An accepted seed beat captures beat 0, goes to LOAD, and forces rand_valid=0 on the next cycle. Simultaneous seed accept and rand handshake: the handshake completes, then the reseed takes over.
- Reset mid-operation: rst wins over every other input in the same cycle; a partially loaded seed is discarded.
- rand=0 whenever the FSM is not in RUN.
- busy = (state==LOAD) | (state==WARMUP).

Test Plan:
1. Apply rst for 2 cycles -> rand_valid=0, rand=0, seed_ready=1, busy=0.
2. WARMUP=0, MODE=0, CHANNELS=1; seed beats 0x40bf then 0xe3a6 (seed32=S1^1, lane0 state=1) -> first rand=0x0001. After one handshake rand=0x0021 (xorshift32(1)=0x00042021 masked to 11 bits).
3. Same seeding, rand_ready=0 for 5 cycles -> rand stays 0x0001 with rand_valid high. Raise rand_ready -> next value 0x0021 the following cycle.
4. Seeds 0x0000,0x0000 with WARMUP=4, CHANNELS=4 -> busy high for LOAD plus 4 cycles. Lanes 0..3 outputs equal the reference model after 4 steps and are pairwise distinct.
5. MODE=1 with a seed whose lane0 low 12 bits ≥ 3329 -> rand_valid=0 that cycle and the lanes step. Every accepted word < 3329 over 1000 handshakes.
6. In RUN, assert a seed beat mid-stream, then rst during LOAD -> rand_valid drops within 1 cycle. After rst the FSM is in IDLE and the stale beat 0 is not reused.
